// File: rtl/approximation_csr_unit.sv
// Approximation-control CSR block: owns the ALU accuracy/enable CSR and the
// saturating approximate-operation counter, serviced by a 4-state Zicsr FSM.
module approximation_csr_unit #(
  parameter logic [11:0] ALUCSR_ADDR    = 12'h800,
  parameter logic [11:0] APXCNT_ADDR    = 12'h801,
  parameter logic [7:0]  RESET_ACCURACY = 8'hFF,
  parameter logic        RESET_ENABLE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_valid,
  input  logic [11:0] csr_index,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1_index,
  input  logic [31:0] rs1,
  output logic [31:0] csr_rdata,
  output logic        csr_done,
  output logic        csr_illegal,
  input  logic        alu_approx_op,
  output logic [7:0]  accuracy_level,
  output logic        approx_enable
);

  // Handshake: csr_valid is held with stable operands until csr_done; it is
  // only sampled in IDLE, and csr_done (qualified by csr_illegal) is a
  // single-cycle pulse carrying csr_rdata.
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [11:0] index_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rs1_index_q;
  logic [31:0] rs1_q;
  logic        illegal_q, illegal_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] new_q, new_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  acc_q, acc_d;
  logic        en_q, en_d;

  logic [31:0] src;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        is_alu;
  logic        suppress;
  logic        commit;

  always_comb begin
    src      = funct3_q[2] ? {27'b0, rs1_index_q} : rs1_q;
    is_alu   = (index_q == ALUCSR_ADDR);
    old_val  = is_alu ? {16'b0, acc_q, 7'b0, en_q} : cnt_q;
    case (funct3_q[1:0])
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
    // Set/clear with x0 (or uimm 0) is a pure read.
    suppress = (funct3_q[1:0] != 2'b01) && (rs1_index_q == 5'd0);
    commit   = (state_q == WRITE) && !illegal_q && !suppress;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    rdata_d   = rdata_q;
    new_d     = new_q;
    case (state_q)
      IDLE: begin
        if (csr_valid) begin
          state_d   = READ;
          illegal_d = ((csr_index != ALUCSR_ADDR) && (csr_index != APXCNT_ADDR)) ||
                      (funct3[1:0] == 2'b00);
        end
      end
      READ: begin
        state_d = WRITE;
        rdata_d = illegal_q ? 32'h0 : old_val;
        new_d   = new_val;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    en_d  = en_q;
    cnt_d = cnt_q;
    if (alu_approx_op && en_q && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    // A CSR write to the counter overrides a same-cycle increment.
    if (commit && !is_alu) cnt_d = new_q;
    if (commit && is_alu) begin
      acc_d = new_q[15:8];
      en_d  = new_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      illegal_q   <= 1'b0;
      rdata_q     <= 32'h0;
      new_q       <= 32'h0;
      cnt_q       <= 32'h0;
      acc_q       <= RESET_ACCURACY;
      en_q        <= RESET_ENABLE;
      index_q     <= 12'h0;
      funct3_q    <= 3'h0;
      rs1_index_q <= 5'h0;
      rs1_q       <= 32'h0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      rdata_q   <= rdata_d;
      new_q     <= new_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      en_q      <= en_d;
      if (state_q == IDLE && csr_valid) begin
        index_q     <= csr_index;
        funct3_q    <= funct3;
        rs1_index_q <= rs1_index;
        rs1_q       <= rs1;
      end
    end
  end

  assign csr_done       = (state_q == DONE);
  assign csr_illegal    = (state_q == DONE) && illegal_q;
  assign csr_rdata      = rdata_q;
  assign accuracy_level = acc_q;
  assign approx_enable  = en_q;

endmodule

// File: tb/tb_approximation_csr_unit.sv
// Directed bench for approximation_csr_unit: driver pushes expected completion
// responses into a queue, a negedge monitor pops and compares on csr_done.
module tb_approximation_csr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_valid;
  logic [11:0] csr_index;
  logic [2:0]  funct3;
  logic [4:0]  rs1_index;
  logic [31:0] rs1;
  logic [31:0] csr_rdata;
  logic        csr_done;
  logic        csr_illegal;
  logic        alu_approx_op;
  logic [7:0]  accuracy_level;
  logic        approx_enable;

  int n_cmp = 0;
  int n_err = 0;

  // {illegal, rdata, accuracy, enable}
  logic [41:0] exp_q[$];

  localparam logic [11:0] ALU = 12'h800;
  localparam logic [11:0] APX = 12'h801;

  approximation_csr_unit dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_index(csr_index),
    .funct3(funct3), .rs1_index(rs1_index), .rs1(rs1), .csr_rdata(csr_rdata),
    .csr_done(csr_done), .csr_illegal(csr_illegal), .alu_approx_op(alu_approx_op),
    .accuracy_level(accuracy_level), .approx_enable(approx_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (csr_done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done with empty queue, expected none");
      end else begin
        logic [41:0] e;
        logic [41:0] a;
        e = exp_q.pop_front();
        a = {csr_illegal, csr_rdata, accuracy_level, approx_enable};
        if (a !== e) begin
          n_err++;
          $display("FAIL done_resp: got ill=%b rdata=%h acc=%h en=%b expected ill=%b rdata=%h acc=%h en=%b",
                   a[41], a[40:9], a[8:1], a[0], e[41], e[40:9], e[8:1], e[0]);
        end
      end
    end
  end

  task automatic csr_op(input logic [11:0] idx, input logic [2:0] f3, input logic [4:0] r1i,
                        input logic [31:0] r1, input logic op_at_commit,
                        input logic ill, input logic [31:0] rd, input logic [7:0] acc,
                        input logic en);
    int lat;
    lat = 0;
    @(negedge clk);
    csr_index = idx; funct3 = f3; rs1_index = r1i; rs1 = r1; csr_valid = 1'b1;
    exp_q.push_back({ill, rd, acc, en});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (csr_done) begin
        lat = c;
        break;
      end
      // Scramble operands while busy; they must have been latched already.
      csr_index = 12'h123; funct3 = 3'b000; rs1 = 32'hDEAD_BEEF; rs1_index = 5'd31;
      if (c == 2 && op_at_commit) alu_approx_op = 1'b1;
    end
    alu_approx_op = 1'b0;
    csr_valid = 1'b0;
    check("latency", lat, 3);
    if (lat == 0 && exp_q.size() != 0) void'(exp_q.pop_back());
  endtask

  task automatic pulses(input int n);
    @(negedge clk);
    alu_approx_op = 1'b1;
    repeat (n) @(negedge clk);
    alu_approx_op = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, csr_rdata, 32'h0);
    check({tag, "_done"}, {31'b0, csr_done}, 32'h0);
    check({tag, "_illegal"}, {31'b0, csr_illegal}, 32'h0);
    check({tag, "_acc"}, {24'b0, accuracy_level}, 32'h0000_00FF);
    check({tag, "_en"}, {31'b0, approx_enable}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; csr_valid = 1'b0; csr_index = 12'h0; funct3 = 3'h0;
    rs1_index = 5'h0; rs1 = 32'h0; alu_approx_op = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Read-only CSRRS x0 of ALUCSR
    csr_op(ALU, 3'b010, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_FF00, 8'hFF, 1'b0);
    // CSRRW: reserved bits dropped
    csr_op(ALU, 3'b001, 5'd3, 32'hFFFF_2A01, 1'b0, 1'b0, 32'h0000_FF00, 8'h2A, 1'b1);
    csr_op(ALU, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0000_2A01, 8'h2A, 1'b1);
    // CSRRCI uimm=1 clears enable; pulses then ignored
    csr_op(ALU, 3'b111, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0000_2A01, 8'h2A, 1'b0);
    pulses(5);
    csr_op(APX, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 8'h2A, 1'b0);
    // CSRRSI uimm=1 re-enables; saturation
    csr_op(ALU, 3'b110, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0000_2A00, 8'h2A, 1'b1);
    csr_op(APX, 3'b001, 5'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 8'h2A, 1'b1);
    pulses(4);
    csr_op(APX, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h2A, 1'b1);
    // CSRRC with register source
    csr_op(APX, 3'b011, 5'd1, 32'h0000_000F, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h2A, 1'b1);
    csr_op(APX, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFF0, 8'h2A, 1'b1);
    // Write wins over a same-cycle increment
    csr_op(APX, 3'b001, 5'd4, 32'h0000_0010, 1'b1, 1'b0, 32'hFFFF_FFF0, 8'h2A, 1'b1);
    csr_op(APX, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0000_0010, 8'h2A, 1'b1);
    // Illegal index and illegal funct3: no state change
    csr_op(12'h802, 3'b001, 5'd1, 32'h0000_0000, 1'b0, 1'b1, 32'h0, 8'h2A, 1'b1);
    csr_op(ALU, 3'b100, 5'd1, 32'h0000_0000, 1'b0, 1'b1, 32'h0, 8'h2A, 1'b1);
    csr_op(ALU, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0000_2A01, 8'h2A, 1'b1);
    csr_op(APX, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0000_0010, 8'h2A, 1'b1);

    // Reset while in WRITE: nothing commits, no completion
    @(negedge clk);
    csr_index = ALU; funct3 = 3'b001; rs1_index = 5'd1; rs1 = 32'h0000_5501; csr_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; csr_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    csr_op(ALU, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0000_FF00, 8'hFF, 1'b0);
    csr_op(APX, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 8'hFF, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
